// File: rtl/ray_column_store.sv
// Double-buffered per-column ray store: DDA beats fill one bank while the renderer
// reads the other; banks exchange on a frame swap pulse once the fill bank is complete.
module ray_column_store #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        ray_in_tvalid,
    input  logic [37:0] ray_in_tdata,
    input  logic        ray_in_tlast,
    output logic        ray_in_tready,
    input  logic        frame_swap_in,
    input  logic        rd_valid_in,
    input  logic [8:0]  rd_hcount_in,
    output logic        rd_valid_out,
    output logic [28:0] rd_data_out,
    output logic        frame_ready_out,
    output logic        shown_valid_out,
    output logic        error_out
);
    localparam logic [8:0] WIDTH  = 9'(SCREEN_WIDTH);
    localparam logic [7:0] MAX_LH = 8'(SCREEN_HEIGHT);

    typedef enum logic {FILLING, COMPLETE} state_t;

    state_t      state;
    logic        fill_bank;
    logic [8:0]  beat_count;
    logic [28:0] mem [2][SCREEN_WIDTH];

    logic [8:0]  hcount;
    logic [7:0]  line_height;
    logic [28:0] wr_data;
    logic        accept;
    logic        in_range;
    logic        count_bad;
    logic [8:0]  count_next;

    assign hcount      = ray_in_tdata[37:29];
    assign line_height = (ray_in_tdata[28:21] > MAX_LH) ? MAX_LH : ray_in_tdata[28:21];
    assign wr_data     = {line_height, ray_in_tdata[20:0]};
    assign in_range    = hcount < WIDTH;
    assign accept      = ray_in_tvalid && ray_in_tready;
    assign count_next  = (beat_count == 9'd511) ? beat_count : beat_count + 9'd1;
    // Compare with one extra bit so a saturated count can never alias the width.
    assign count_bad   = ({1'b0, beat_count} + 10'd1) != {1'b0, WIDTH};

    assign ray_in_tready   = (state == FILLING) && !rst_in;
    assign frame_ready_out = (state == COMPLETE);

    // Bank storage carries no reset; shown_valid_out masks never-written contents.
    always_ff @(posedge pixel_clk_in) begin
        if (accept && in_range)
            mem[fill_bank][hcount] <= wr_data;
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= FILLING;
            fill_bank       <= 1'b0;
            beat_count      <= 9'd0;
            shown_valid_out <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            case (state)
                FILLING: begin
                    if (accept) begin
                        beat_count <= count_next;
                        if (!in_range)
                            error_out <= 1'b1;
                        if (ray_in_tlast) begin
                            state <= COMPLETE;
                            if (count_bad)
                                error_out <= 1'b1;
                        end
                    end
                end
                COMPLETE: begin
                    if (frame_swap_in) begin
                        fill_bank       <= ~fill_bank;
                        beat_count      <= 9'd0;
                        shown_valid_out <= 1'b1;
                        state           <= FILLING;
                    end
                end
                default: state <= FILLING;
            endcase
        end
    end

    // Reads use the pre-swap bank select, so a read in the swap cycle sees the old frame.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_valid_out <= 1'b0;
            rd_data_out  <= 29'd0;
        end else begin
            rd_valid_out <= rd_valid_in;
            if (rd_valid_in) begin
                if (shown_valid_out && rd_hcount_in < WIDTH)
                    rd_data_out <= mem[~fill_bank][rd_hcount_in];
                else
                    rd_data_out <= 29'd0;
            end
        end
    end

endmodule

// File: tb/tb_ray_column_store.sv
// Bench for ray_column_store: a shown/back frame model checked every cycle,
// plus hand-computed literal expectations over directed frame sequences.
module tb_ray_column_store;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic [37:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        swap = 1'b0;
    logic        rd_valid_in = 1'b0;
    logic [8:0]  rd_hcount = '0;
    logic        rd_valid_out;
    logic [28:0] rd_data;
    logic        frame_ready;
    logic        shown_valid;
    logic        error;

    int checks = 0;
    int errors = 0;

    ray_column_store #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(180)) dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst),
        .ray_in_tvalid   (tvalid),
        .ray_in_tdata    (tdata),
        .ray_in_tlast    (tlast),
        .ray_in_tready   (tready),
        .frame_swap_in   (swap),
        .rd_valid_in     (rd_valid_in),
        .rd_hcount_in    (rd_hcount),
        .rd_valid_out    (rd_valid_out),
        .rd_data_out     (rd_data),
        .frame_ready_out (frame_ready),
        .shown_valid_out (shown_valid),
        .error_out       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] mk(input int col, input int s);
        logic [8:0]  c  = 9'(col);
        logic [7:0]  lh = 8'(col * 3 + s);
        logic [3:0]  md = 4'(col + s);
        logic [15:0] wx = 16'(col * 97 + s * 1000);
        return {c, lh, c[0], md, wx};
    endfunction

    function automatic logic [28:0] expect_payload(input logic [37:0] d);
        logic [7:0] lh = d[28:21];
        if (lh > 8'd180) lh = 8'd180;
        return {lh, d[20:0]};
    endfunction

    // Model: frames as two plain arrays, the one on screen and the one being filled.
    logic [28:0] shown_f [320];
    logic [28:0] back_f  [320];
    logic        m_complete = 1'b0;
    logic        m_shown = 1'b0;
    logic        m_err = 1'b0;
    int          m_count = 0;
    logic        m_rdv = 1'b0;
    logic [28:0] m_rdd = '0;
    wire  [8:0]  in_col = tdata[37:29];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_complete <= 1'b0;
            m_shown    <= 1'b0;
            m_err      <= 1'b0;
            m_count    <= 0;
            m_rdv      <= 1'b0;
            m_rdd      <= '0;
        end else begin
            m_rdv <= rd_valid_in;
            if (rd_valid_in)
                m_rdd <= (m_shown && rd_hcount < 9'd320) ? shown_f[rd_hcount] : 29'd0;
            if (tvalid && !m_complete) begin
                if (in_col < 9'd320) back_f[in_col] <= expect_payload(tdata);
                else m_err <= 1'b1;
                m_count <= m_count + 1;
                if (tlast) begin
                    m_complete <= 1'b1;
                    if (m_count + 1 != 320) m_err <= 1'b1;
                end
            end
            if (swap && m_complete) begin
                for (int i = 0; i < 320; i++) begin
                    shown_f[i] <= back_f[i];
                    back_f[i]  <= shown_f[i];
                end
                m_complete <= 1'b0;
                m_count    <= 0;
                m_shown    <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("tready", 32'(tready), 32'(!m_complete && !rst));
        chk("frame_ready", 32'(frame_ready), 32'(m_complete));
        chk("shown_valid", 32'(shown_valid), 32'(m_shown));
        chk("error", 32'(error), 32'(m_err));
        chk("rd_valid", 32'(rd_valid_out), 32'(m_rdv));
        chk("rd_data", 32'(rd_data), 32'(m_rdd));
    end

    task automatic beat(input logic [37:0] d, input logic last, input logic sw);
        tvalid = 1'b1; tdata = d; tlast = last; swap = sw;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; swap = 1'b0;
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        @(posedge clk); #1;
        swap = 1'b0;
    endtask

    task automatic rd(input int col);
        rd_valid_in = 1'b1; rd_hcount = 9'(col);
        @(posedge clk); #1;
        rd_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic full_frame(input int s);
        for (int c = 0; c < 320; c++) beat(mk(c, s), c == 319, 1'b0);
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        idle(1);
        chk("tready_after_rst", 32'(tready), 32'd1);

        // Frame A, in order
        full_frame(1);
        chk("A_frame_ready", 32'(frame_ready), 32'd1);
        chk("A_tready_low", 32'(tready), 32'd0);
        pulse_swap();
        chk("A_shown", 32'(shown_valid), 32'd1);
        rd(17);
        chk("A_col17", 32'(rd_data), 32'({8'd52, 1'b1, 4'd2, 16'd2649}));

        // Frame B, even columns then odd
        for (int c = 0; c < 320; c += 2) beat(mk(c, 2), 1'b0, 1'b0);
        for (int c = 1; c < 320; c += 2) beat(mk(c, 2), c == 319, 1'b0);
        pulse_swap();
        for (int c = 0; c < 320; c++) rd(c);
        idle(1);
        chk("B_no_error", 32'(error), 32'd0);

        // Frame C with swap pulses ignored while filling
        for (int c = 0; c < 320; c++) beat(mk(c, 3), c == 319, (c % 50) == 10);
        rd(5);
        chk("C_still_B", 32'(rd_data), 32'(expect_payload(mk(5, 2))));
        swap = 1'b1; rd(9); swap = 1'b0;
        chk("swap_cycle_old", 32'(rd_data), 32'(expect_payload(mk(9, 2))));
        rd(9);
        chk("after_swap_new", 32'(rd_data), 32'(expect_payload(mk(9, 3))));

        // Frame D: out-of-range column, short frame
        beat(mk(330, 4), 1'b0, 1'b0);
        for (int c = 0; c < 199; c++) beat(mk(c, 4), c == 198, 1'b0);
        chk("D_error", 32'(error), 32'd1);
        chk("D_frame_ready", 32'(frame_ready), 32'd1);
        pulse_swap();
        rd(100); rd(250); rd(330);
        chk("rd_out_of_range", 32'(rd_data), 32'd0);

        // Frame E: tlast together with a swap pulse
        for (int c = 0; c < 319; c++) beat(mk(c, 5), 1'b0, 1'b0);
        beat(mk(319, 5), 1'b1, 1'b1);
        chk("E_tready_low", 32'(tready), 32'd0);
        chk("E_pending", 32'(frame_ready), 32'd1);
        rd(0);
        chk("E_not_swapped", 32'(rd_data), 32'(expect_payload(mk(0, 4))));
        pulse_swap();
        rd(0);
        idle(1);

        // Frame F: lineHeight clamp on column 3
        for (int c = 0; c < 320; c++)
            beat((c == 3) ? {9'd3, 8'd255, 1'b1, 4'd9, 16'd6291} : mk(c, 6), c == 319, 1'b0);
        pulse_swap();
        rd(3);
        chk("clamp_180", 32'(rd_data), 32'({8'd180, 1'b1, 4'd9, 16'd6291}));

        // Frame G interrupted by asynchronous reset
        for (int c = 0; c < 50; c++) beat(mk(c, 7), 1'b0, 1'b0);
        rd_valid_in = 1'b1; rd_hcount = 9'd4;
        @(posedge clk); #3;
        rst = 1'b1; rd_valid_in = 1'b0;
        #1;
        chk("arst_tready", 32'(tready), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid_out), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_shown", 32'(shown_valid), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        chk("arst_frame_ready", 32'(frame_ready), 32'd0);
        idle(2);
        rst = 1'b0;
        #1;
        chk("tready_release", 32'(tready), 32'd1);
        rd(10);
        chk("masked_before_swap", 32'(rd_data), 32'd0);

        // Frame H after reset
        full_frame(8);
        pulse_swap();
        rd(0); rd(160); rd(319);
        chk("H_col319", 32'(rd_data), 32'(expect_payload(mk(319, 8))));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ray_column_store.md
# ray_column_store

Double-buffered per-column store downstream of the DDA output FIFO. Accepts one 38-bit ray result per beat, in any column order, and writes it into the fill bank at index `hcount_ray`. When the frame's `tlast` beat arrives, the fill bank is marked complete. On the next `frame_swap_in` pulse the banks exchange, so the column renderer always reads a complete, stable frame through a 1-cycle-latency read port.

## Interface
- `SCREEN_WIDTH`, 320, number of columns (entries per bank).
- `SCREEN_HEIGHT`, 180, informational; bounds `lineHeight` clamp.
- `pixel_clk_in`  in  1  sole clock, rising edge.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `ray_in_tvalid`  in  1  beat valid.
- `ray_in_tdata`  in  38  beat payload, fields as listed below.
  - [37:29] `hcount_ray`
  - [28:21] `lineHeight`
  - [20] `wallType`
  - [19:16] `mapData`
  - [15:0] `wallX`
- `ray_in_tlast`  in  1  marks the last ray of a frame.
- `ray_in_tready`  out  1  sink ready.
- `frame_swap_in`  in  1  single-cycle pulse from display timing (start of vblank).
- `rd_valid_in`  in  1  read request.
- `rd_hcount_in`  in  9  column to read.
- `rd_valid_out`  out  1  read data valid.
- `rd_data_out`  out  29  `{lineHeight[7:0], wallType, mapData[3:0], wallX[15:0]}`.
- `frame_ready_out`  out  1  fill bank complete, awaiting swap.
- `shown_valid_out`  out  1  at least one swap has occurred; read bank holds a real frame.
- `error_out`  out  1  sticky protocol error.

## Operation
- Storage: two banks, each `SCREEN_WIDTH` entries × 29 bits. A `fill_bank` bit selects the write bank; the read bank is `!fill_bank`.
- Sink:
  - `ray_in_tready = !frame_complete` (registered state), forced 0 while `rst_in` is high.
  - On `tvalid && tready`:
    - If `hcount_ray < SCREEN_WIDTH`, write fields to `fill_bank[hcount_ray]`. `lineHeight` is clamped to `SCREEN_HEIGHT` when larger.
    - Increment `beat_count` (9 bits, saturating at 511).
  - A later beat to the same column overwrites the earlier one.
- Frame completion: an accepted beat with `tlast=1` sets `frame_complete`. The `tlast` beat itself is written.
  - Set `error_out` if `beat_count + 1 != SCREEN_WIDTH` at that beat.
  - Set `error_out` on any accepted beat with `hcount_ray >= SCREEN_WIDTH`; that beat is dropped but still counted.
- Swap state machine, two states:
  - FILLING (`frame_complete=0`): a swap pulse is ignored. The read bank keeps the old frame and the display repeats it.
  - COMPLETE (`frame_complete=1`): on a swap pulse, toggle `fill_bank`, clear `frame_complete`, clear `beat_count`, set `shown_valid_out`. Return to FILLING.
- Read port:
  - `rd_data_out` is registered from `read_bank[rd_hcount_in]` when `rd_valid_in` is high.
  - Returns 0 if `rd_hcount_in >= SCREEN_WIDTH` or `shown_valid_out=0`.
  - Holds its last value when `rd_valid_in` is low.
- `error_out` is cleared only by reset.
- Reset: asynchronous assertion immediately sets the following:
  - `ray_in_tready=0`, `rd_valid_out=0`, `rd_data_out=0`
  - `frame_ready_out=0`, `shown_valid_out=0`, `error_out=0`
  - `fill_bank=0`, `beat_count=0`, `frame_complete=0`
- Bank contents are not reset. `shown_valid_out` masks stale data.
- Reset mid-frame discards the partial frame.

## Timing
- Write: one beat per cycle sustained while in FILLING; no bubbles.
- `tready` falls the cycle after the `tlast` beat is accepted. It rises the cycle after the swap is taken.
- `frame_ready_out` equals `frame_complete`, registered; it goes high the cycle after the `tlast` beat.
- Swap takes effect on the clock edge where `frame_swap_in` is sampled high in COMPLETE. A read issued that same cycle returns the old read bank; reads from the next cycle return the new frame.
- Simultaneous `tlast` beat and `frame_swap_in`: the beat is written and `frame_complete` is set. The swap is not taken (state was FILLING) and waits for the next pulse.
- Read latency: exactly 1 cycle. `rd_valid_out` is `rd_valid_in` delayed by 1 cycle.
- A write and a read to the same index never conflict, because they always target different banks.

## Test plan
- Reset, then 320 beats with `hcount_ray` 0..319 in order, `tlast` on 319. `frame_ready_out=1` one cycle after; `tready=0`. Pulse swap. `shown_valid_out=1`; reading column 17 returns the payload sent for column 17 one cycle later.
- Interleaved order (even columns first, then odd columns), `tlast` on final beat, swap. All 320 columns read back correctly; `error_out=0`.
- Frame B sent, but its swap is withheld while display swap pulses occur during FILLING. Reads keep returning frame A until frame B completes and a swap is taken.
- Beat with `hcount_ray=330`; `tlast` arrives after 200 beats. `error_out=1`; no write for 330; `frame_ready_out=1`.
- `tlast` beat and swap pulse in the same cycle. No swap occurs and `tready=0`; the next swap pulse exchanges banks.
- Beat with `lineHeight=255` → reads back 180. Assert `rst_in` mid-frame → all outputs 0 asynchronously; `tready=1` after release.
